mem_access_ctrl: RTL and testbench

//  Load/store sequencer between the core's execute stage and the 8-bit data memory.

---
 rtl/mem_access_ctrl_if.sv | 33 +++
 rtl/mem_access_ctrl.sv | 102 ++++++++++
 tb/tb_mem_access_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Load/store request channel plus byte-wide data-memory port of mem_access_ctrl.
//   Request side : req, is_store, pair, sext, addr, wdata -> ready, done, rdata
//   Memory side  : mem_addr, mem_rd, mem_wr, mem_wdata -> mem_rdata (combinational read)
//   master : execute stage plus data memory (drives requests, returns mem_rdata)
//   slave  : the sequencer itself
interface mem_access_ctrl_if #(
   parameter int unsigned AW = 8
);
   logic          req;
   logic          is_store;
   logic          pair;
   logic          sext;
   logic [AW-1:0] addr;
   logic [15:0]   wdata;
   logic          ready;
   logic          done;
   logic [15:0]   rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic          mem_wr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;

   modport master (
      output req, is_store, pair, sext, addr, wdata, mem_rdata,
      input  ready, done, rdata, mem_addr, mem_rd, mem_wr, mem_wdata
   );

   modport slave (
      input  req, is_store, pair, sext, addr, wdata, mem_rdata,
      output ready, done, rdata, mem_addr, mem_rd, mem_wr, mem_wdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the execute stage and an 8-bit data memory.
// Performs one byte or little-endian byte-pair access per request in one or
// two memory cycles, then pulses done for one cycle with rdata already valid.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : mem_access_ctrl_if.slave (request channel + memory port)
// All outputs, including the memory-side controls, are registered.
module mem_access_ctrl #(
   parameter int unsigned AW = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_access_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state;
   logic          storeQ;
   logic          pairQ;
   logic          sextQ;
   logic [AW-1:0] addrQ;
   logic [15:0]   wdataQ;
   logic [7:0]    loQ;

   // Sequencer; memory controls are set up on the edge entering each access
   // state so they come straight from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         storeQ        <= 1'b0;
         pairQ         <= 1'b0;
         sextQ         <= 1'b0;
         addrQ         <= '0;
         wdataQ        <= '0;
         loQ           <= '0;
         bus.ready     <= 1'b1;
         bus.done      <= 1'b0;
         bus.rdata     <= '0;
         bus.mem_addr  <= '0;
         bus.mem_rd    <= 1'b0;
         bus.mem_wr    <= 1'b0;
         bus.mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req) begin
                  state         <= ACC0;
                  storeQ        <= bus.is_store;
                  pairQ         <= bus.pair;
                  sextQ         <= bus.sext;
                  addrQ         <= bus.addr;
                  wdataQ        <= bus.wdata;
                  bus.ready     <= 1'b0;
                  bus.mem_addr  <= bus.addr;
                  bus.mem_rd    <= ~bus.is_store;
                  bus.mem_wr    <= bus.is_store;
                  bus.mem_wdata <= bus.wdata[7:0];
               end
            end
            ACC0: begin
               if (!storeQ) loQ <= bus.mem_rdata;
               if (pairQ) begin
                  // Second byte address wraps modulo the memory depth.
                  state         <= ACC1;
                  bus.mem_addr  <= addrQ + AW'(1);
                  bus.mem_wdata <= wdataQ[15:8];
               end else begin
                  state      <= DONE;
                  bus.mem_rd <= 1'b0;
                  bus.mem_wr <= 1'b0;
                  bus.done   <= 1'b1;
                  if (!storeQ)
                     bus.rdata <= {{8{bus.mem_rdata[7] & sextQ}}, bus.mem_rdata};
               end
            end
            ACC1: begin
               state      <= DONE;
               bus.mem_rd <= 1'b0;
               bus.mem_wr <= 1'b0;
               bus.done   <= 1'b1;
               if (!storeQ) bus.rdata <= {bus.mem_rdata, loQ};
            end
            DONE: begin
               state     <= IDLE;
               bus.done  <= 1'b0;
               bus.ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               bus.done  <= 1'b0;
               bus.ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases, random ops and a
// held-req phase, scored against a byte-array reference memory.
module tb_mem_access_ctrl;

   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 2 ** AW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mem_access_ctrl_if #(.AW(AW)) bus ();

   mem_access_ctrl #(.AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0]  mem    [DEPTH];
   logic [7:0]  refMem [DEPTH];
   bit          memInit = 1'b0;
   int          total   = 0;
   int          bad     = 0;
   logic [15:0] lastRd  = 16'h0000;

   // Data memory attached to the DUT: combinational read, write on rising edge.
   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (!memInit) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'(i * 37 + 5);
         memInit <= 1'b1;
      end else if (bus.mem_wr) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Memory strobes: never both high, and quiet whenever the block is idle.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("rdWrExcl", 16'(bus.mem_rd & bus.mem_wr), 16'h0);
         if (bus.ready) chk("idleStrobes", 16'({bus.mem_rd, bus.mem_wr}), 16'h0);
      end
   end

   // Reference: apply the whole operation to refMem and predict rdata/latency.
   task automatic refOp(input bit st, input bit pr, input bit sx,
                        input logic [AW-1:0] a, input logic [15:0] wd,
                        output int expLat);
      logic [AW-1:0] a1;
      a1 = a + AW'(1);
      if (st) begin
         refMem[a] = wd[7:0];
         if (pr) refMem[a1] = wd[15:8];
      end else if (pr) begin
         lastRd = {refMem[a1], refMem[a]};
      end else if (sx) begin
         lastRd = 16'($signed(refMem[a]));
      end else begin
         lastRd = {8'h00, refMem[a]};
      end
      expLat = pr ? 3 : 2;
   endtask

   // Issue one op from a falling edge; hold keeps req asserted while busy.
   task automatic doOp(input bit st, input bit pr, input bit sx,
                       input logic [AW-1:0] a, input logic [15:0] wd, input bit hold);
      int w;
      int lat;
      int expLat;
      bus.req      = 1'b1;
      bus.is_store = st;
      bus.pair     = pr;
      bus.sext     = sx;
      bus.addr     = a;
      bus.wdata    = wd;
      w = 0;
      while (!bus.ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("acceptReady", 16'(bus.ready), 16'h1);
      if (!bus.ready) begin
         bus.req = 1'b0;
         return;
      end
      @(posedge clk);
      refOp(st, pr, sx, a, wd, expLat);
      @(negedge clk);
      // Inputs while busy are don't-care; scramble them to prove they are latched.
      bus.req      = hold;
      bus.is_store = 1'($urandom);
      bus.pair     = 1'($urandom);
      bus.sext     = 1'($urandom);
      bus.addr     = AW'($urandom);
      bus.wdata    = 16'($urandom);
      lat = 1;
      while (!bus.done && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 16'(lat), 16'(expLat));
      chk("rdata", bus.rdata, lastRd);
      chk("readyInDone", 16'(bus.ready), 16'h0);
      @(negedge clk);
      chk("donePulse", 16'(bus.done), 16'h0);
      chk("readyAfter", 16'(bus.ready), 16'h1);
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) refMem[i] = 8'(i * 37 + 5);
      bus.req      = 1'b0;
      bus.is_store = 1'b0;
      bus.pair     = 1'b0;
      bus.sext     = 1'b0;
      bus.addr     = '0;
      bus.wdata    = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rstReady", 16'(bus.ready), 16'h1);
      chk("rstDone", 16'(bus.done), 16'h0);
      chk("rstRdata", bus.rdata, 16'h0);
      chk("rstMemRd", 16'(bus.mem_rd), 16'h0);
      chk("rstMemWr", 16'(bus.mem_wr), 16'h0);
      chk("rstMemAddr", 16'(bus.mem_addr), 16'h0);
      chk("rstMemWdata", 16'(bus.mem_wdata), 16'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Byte store then zero-extended byte load
      doOp(1'b1, 1'b0, 1'b0, 8'h11, 16'h00A5, 1'b0);
      chk("mem11", 16'(mem[8'h11]), 16'h00A5);
      doOp(1'b0, 1'b0, 1'b0, 8'h11, 16'h0000, 1'b0);
      chk("ldByteZ", bus.rdata, 16'h00A5);

      // Sign vs zero extension of 0x80
      doOp(1'b1, 1'b0, 1'b0, 8'h20, 16'h0080, 1'b0);
      doOp(1'b0, 1'b0, 1'b1, 8'h20, 16'h0000, 1'b0);
      chk("ldSext", bus.rdata, 16'hFF80);
      doOp(1'b0, 1'b0, 1'b0, 8'h20, 16'h0000, 1'b0);
      chk("ldZext", bus.rdata, 16'h0080);

      // Pair store/load, little-endian
      doOp(1'b1, 1'b1, 1'b0, 8'h30, 16'hBEEF, 1'b0);
      chk("mem30", 16'(mem[8'h30]), 16'h00EF);
      chk("mem31", 16'(mem[8'h31]), 16'h00BE);
      doOp(1'b0, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b0);
      chk("ldPair", bus.rdata, 16'hBEEF);

      // Reset asserted during ACC0 of a store drops mem_wr at once
      bus.req      = 1'b1;
      bus.is_store = 1'b1;
      bus.pair     = 1'b1;
      bus.sext     = 1'b0;
      bus.addr     = 8'h50;
      bus.wdata    = 16'h5A5A;
      @(posedge clk);
      @(negedge clk);
      bus.req = 1'b0;
      chk("wrInAcc0", 16'(bus.mem_wr), 16'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("wrDropAsync", 16'(bus.mem_wr), 16'h0);
      chk("rstMidReady", 16'(bus.ready), 16'h1);
      chk("rstMidRdata", bus.rdata, 16'h0);
      @(negedge clk);
      rst_n  = 1'b1;
      lastRd = 16'h0000;
      @(negedge clk);
      chk("mem50Untouched", 16'(mem[8'h50]), 16'(refMem[8'h50]));

      // Pair access wrapping from 0xFF to 0x00
      doOp(1'b1, 1'b1, 1'b0, 8'hFF, 16'h1234, 1'b0);
      chk("memFF", 16'(mem[8'hFF]), 16'h0034);
      chk("mem00", 16'(mem[8'h00]), 16'h0012);
      doOp(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0);
      chk("ldWrap", bus.rdata, 16'h1234);

      // Random ops, addresses biased toward the wrap point
      for (int n = 0; n < 150; n++) begin
         logic [AW-1:0] a;
         a = ($urandom_range(0, 3) == 0) ? AW'(DEPTH - 1 - $urandom_range(0, 1)) : AW'($urandom);
         doOp(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), 1'b0);
      end

      // req held high across ops, alternating store/load
      for (int n = 0; n < 40; n++) begin
         doOp(1'(n % 2 == 0), 1'($urandom), 1'($urandom), AW'($urandom), 16'($urandom),
              1'(n != 39));
      end
      bus.req = 1'b0;
      repeat (2) @(negedge clk);

      // Whole-memory comparison against the reference
      for (int i = 0; i < int'(DEPTH); i++) chk("memFinal", 16'(mem[i]), 16'(refMem[i]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
